// File: rtl/iter_divider_4bit.sv
// rtl/iter_divider_4bit.sv - multi-cycle restoring divider with valid/ready handshake (optional SIGNED_DIV_EN)
module iter_divider_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             dbz_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign in_ready = (state == IDLE);
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  // shifted < 2*dvs, so bit WIDTH of the wrapped difference is exactly the borrow
  assign borrow   = diff[WIDTH];

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
  logic ovf_q;
  logic ovf_case;

  assign a_mag    = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag    = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign ovf_case = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == {WIDTH{1'b1}});

  // sign bookkeeping captured at accept, applied when the result is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_q    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r    <= dividend[WIDTH-1];
      ovf_q    <= ovf_case;
      overflow <= 1'b0;
    end else if (state == DONE && !out_valid && !dbz_q) begin
      overflow <= ovf_q;
    end
  end
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign overflow = 1'b0;
`endif

  // control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      dbz_q       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_by_zero <= 1'b0;
            dvs         <= b_mag;
            if (divisor == '0) begin
              // zero divisor skips the core: all-ones quotient, raw dividend as remainder
              dbz_q <= 1'b1;
              dvd   <= '1;
              rem   <= dividend;
              state <= DONE;
            end else begin
              dbz_q <= 1'b0;
              dvd   <= a_mag;
              rem   <= '0;
              cnt   <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ~borrow};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            // first DONE edge registers the result (and sign fix-up) and raises out_valid
            out_valid <= 1'b1;
            if (dbz_q) begin
              quotient    <= dvd;
              remainder   <= rem;
              div_by_zero <= 1'b1;
            end else begin
`ifdef SIGNED_DIV_EN
              if (ovf_q) begin
                quotient  <= {1'b1, {(WIDTH-1){1'b0}}};
                remainder <= '0;
              end else begin
                quotient  <= neg_q ? -dvd : dvd;
                remainder <= neg_r ? -rem : rem;
              end
`else
              quotient  <= dvd;
              remainder <= rem;
`endif
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider_4bit.sv
// tb/tb_iter_divider_4bit.sv - directed self-checking bench for iter_divider_4bit
module tb_iter_divider_4bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  iter_divider_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // accept one operand pair, wait for the result with out_ready low, check, then hand it off
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int lat, input logic [3:0] eq, input logic [3:0] er,
                         input logic edbz, input logic eovf);
    int  n;
    bit  got;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (out_valid) got = 1;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_quotient"}, int'(quotient), int'(eq));
    check({tag, "_remainder"}, int'(remainder), int'(er));
    check({tag, "_div_by_zero"}, int'(div_by_zero), int'(edbz));
    check({tag, "_overflow"}, int'(overflow), int'(eovf));
    check({tag, "_in_ready_done"}, int'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, int'(out_valid), 0);
    check({tag, "_in_ready_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    bit saw_valid;
    logic [3:0] bp_a, bp_q, bp_r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    check("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick();

    // reset during CALC abandons the division
    dividend = 4'd6;
    divisor  = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("calc_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1;
    end
    check("midrst_no_result", int'(saw_valid), 0);
    check("midrst_quotient", int'(quotient), 0);

`ifdef SIGNED_DIV_EN
    run_div("s_m7_2", 4'b1001, 4'b0010, 5, 4'b1101, 4'b1111, 1'b0, 1'b0);
    run_div("s_7_m2", 4'b0111, 4'b1110, 5, 4'b1101, 4'b0001, 1'b0, 1'b0);
    run_div("s_m8_m1", 4'b1000, 4'b1111, 5, 4'b1000, 4'b0000, 1'b0, 1'b1);
    run_div("s_m6_3", 4'b1010, 4'b0011, 5, 4'b1110, 4'b0000, 1'b0, 1'b0);
    bp_a = 4'd5;
    bp_q = 4'd1;
    bp_r = 4'd2;
`else
    run_div("u_13_4", 4'd13, 4'd4, 5, 4'b0011, 4'b0001, 1'b0, 1'b0);
    run_div("u_15_1", 4'd15, 4'd1, 5, 4'b1111, 4'b0000, 1'b0, 1'b0);
    run_div("u_14_5", 4'd14, 4'd5, 5, 4'b0010, 4'b0100, 1'b0, 1'b0);
    bp_a = 4'd10;
    bp_q = 4'd3;
    bp_r = 4'd1;
`endif
    run_div("d_3_7", 4'd3, 4'd7, 5, 4'b0000, 4'b0011, 1'b0, 1'b0);
    run_div("d_9_0", 4'd9, 4'd0, 1, 4'b1111, 4'b1001, 1'b1, 1'b0);
    run_div("d_6_2", 4'd6, 4'd2, 5, 4'b0011, 4'b0000, 1'b0, 1'b0);

    // backpressure: result held while out_ready is low, new operands ignored
    dividend = bp_a;
    divisor  = 4'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_out_valid", int'(out_valid), 1);
    dividend = 4'd15;
    divisor  = 4'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_quotient", int'(quotient), int'(bp_q));
      check("bp_hold_remainder", int'(remainder), int'(bp_r));
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    tick();
    check("bp_ignored_in_ready", int'(in_ready), 1);
    check("bp_ignored_quotient", int'(quotient), int'(bp_q));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
